bot_updt_handshake: RTL

- Handshake stage between the Rojobot and the MIPS system's I/O. It sits directly upstream of the system's IO_BotUpdt_Sync / IO_BotInfo inputs and consumes its IO_INT_ACK output.
- It synchronises the raw Rojobot update strobe and raises a level-held update flag until the CPU acknowledges it.
- It snapshots BotInfo so the CPU always reads a coherent 32-bit word, and it counts overruns and acknowledge timeouts for firmware diagnostics.

---
 rtl/bot_updt_handshake.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/bot_updt_handshake.sv
// Handshake between the Rojobot update strobe and the MIPS I/O port.
// Synchronises the raw strobe, holds a pending flag until the CPU acks it,
// snapshots the info word, and keeps overrun/update/timeout diagnostics.
module bot_updt_handshake #(
  parameter int unsigned TIMEOUT_CYC = 5000000,
  parameter int unsigned TMR_W       = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        BotUpdt,
  input  logic [31:0] BotInfo_in,
  input  logic        IO_INT_ACK,
  output logic        IO_BotUpdt_Sync,
  output logic [31:0] IO_BotInfo,
  output logic [7:0]  Overrun_Cnt,
  output logic [15:0] Updt_Cnt,
  output logic        Ack_Timeout
);

  localparam logic [TMR_W-1:0] TmrMax = TMR_W'(TIMEOUT_CYC);
  // Timeout asserts on the increment that brings the timer to TIMEOUT_CYC-1.
  localparam logic [TMR_W-1:0] TmrSet = TMR_W'(TIMEOUT_CYC - 2);

  typedef enum logic [0:0] {StIdle, StPending} state_e;

  state_e            state_q, state_d;
  logic              s1, s2, s3;
  logic              lvl1, lvl2;
  logic              hold_q;
  logic              ack_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              tout_q, tout_d;
  logic [31:0]       info_q;
  logic [7:0]        ovr_q;
  logic [15:0]       updt_q;
  logic              capture, overrun;
  logic              upd_rise, ack_rise;

  // Three-stage synchroniser for the raw update strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= BotUpdt;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Unreset level tracker: lets reset see whether the strobe is already high.
  always_ff @(posedge clk) begin
    lvl1 <= BotUpdt;
    lvl2 <= lvl1;
  end

  // A strobe still high through reset counts as consumed until it drops low.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= lvl2;
    end else if (!lvl2) begin
      hold_q <= 1'b0;
    end
  end

  // Ack edge detector register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_d <= 1'b0;
    end else begin
      ack_d <= IO_INT_ACK;
    end
  end

  assign upd_rise = s2 & ~s3 & ~hold_q;
  assign ack_rise = IO_INT_ACK & ~ack_d;

  // Next-state, capture and timer decisions.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    tout_d  = tout_q;
    capture = 1'b0;
    overrun = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (upd_rise) begin
          state_d = StPending;
          capture = 1'b1;
          timer_d = '0;
          tout_d  = 1'b0;
        end
      end
      StPending: begin
        if (upd_rise) begin
          capture = 1'b1;
          timer_d = '0;
          if (ack_rise) begin
            // New update replaces the one just acknowledged.
            tout_d = 1'b0;
          end else begin
            overrun = 1'b1;
          end
        end else if (ack_rise) begin
          state_d = StIdle;
          timer_d = '0;
          tout_d  = 1'b0;
        end else begin
          if (timer_q != TmrMax) begin
            timer_d = timer_q + 1'b1;
          end
          if (timer_q == TmrSet) begin
            tout_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, snapshot and diagnostic counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      timer_q <= '0;
      tout_q  <= 1'b0;
      info_q  <= 32'h0;
      ovr_q   <= 8'h0;
      updt_q  <= 16'h0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      tout_q  <= tout_d;
      if (capture) begin
        info_q <= BotInfo_in;
        updt_q <= updt_q + 16'h1;
      end
      if (overrun && (ovr_q != 8'hFF)) begin
        ovr_q <= ovr_q + 8'h1;
      end
    end
  end

  assign IO_BotUpdt_Sync = (state_q == StPending);
  assign IO_BotInfo      = info_q;
  assign Overrun_Cnt     = ovr_q;
  assign Updt_Cnt        = updt_q;
  assign Ack_Timeout     = tout_q;

endmodule
